// File: rtl/ir_pkg.sv
// Shared IR link definitions: burst pulse counts, receiver states
// and command bit positions used by both ends of the link.
package ir_pkg;

    // Carrier periods per burst class, and the tolerance on each
    localparam int IR_START_PULSES = 88;
    localparam int IR_SEL_PULSES   = 22;
    localparam int IR_ZERO_PULSES  = 20;
    localparam int IR_ONE_PULSES   = 47;
    localparam int IR_TOL          = 4;

    // Width of the burst pulse counter; all-ones means saturated
    localparam int PULSE_W = 8;

    // Position of each drive direction within the command word
    localparam int CMD_RIGHT    = 0;
    localparam int CMD_LEFT     = 1;
    localparam int CMD_BACKWARD = 2;
    localparam int CMD_FORWARD  = 3;
    localparam int CMD_BITS     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        BITS,
        DONE
    } ir_state_t;

    // Which burst classes a finished burst falls into
    typedef struct packed {
        logic is_start;
        logic is_sel;
        logic is_zero;
        logic is_one;
    } burst_class_t;

    // A saturated count is never trusted as a match
    function automatic logic count_match(
        input logic [PULSE_W-1:0] c,
        input int                 n,
        input int                 tol
    );
        int ci;
        ci = int'(c);
        return (c != {PULSE_W{1'b1}})
            && (ci >= n - tol)
            && (ci <= n + tol);
    endfunction

endpackage

// File: rtl/ir_envelope_detector.sv
// Recovers the carrier envelope from the raw IR pin and counts the
// carrier pulses making up each burst.
module ir_envelope_detector
    import ir_pkg::*;
#(
    parameter int ENV_TIMEOUT = 4000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IR_IN,
    output logic               ENV,
    output logic               BURST_END,
    output logic [PULSE_W-1:0] PULSE_COUNT
);

    localparam int IW = $clog2(ENV_TIMEOUT + 1);

    // [0],[1] synchroniser stages, [2] previous synchronised value
    logic [2:0]         sync_q;
    logic               rise;
    logic [IW-1:0]      idle_cnt;
    logic [PULSE_W-1:0] pulse_cnt;

    assign rise = sync_q[1] & ~sync_q[2];

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], IR_IN};
        end
    end

    // Track the envelope, count pulses, and report each finished burst
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ENV         <= 1'b0;
            BURST_END   <= 1'b0;
            PULSE_COUNT <= '0;
            idle_cnt    <= '0;
            pulse_cnt   <= '0;
        end else begin
            BURST_END <= 1'b0;
            if (rise) begin
                ENV      <= 1'b1;
                idle_cnt <= '0;
                if (pulse_cnt != {PULSE_W{1'b1}}) begin
                    pulse_cnt <= pulse_cnt + 1'b1;
                end
            end else if (ENV) begin
                if (idle_cnt == IW'(ENV_TIMEOUT - 1)) begin
                    ENV         <= 1'b0;
                    BURST_END   <= 1'b1;
                    PULSE_COUNT <= pulse_cnt;
                    pulse_cnt   <= '0;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ir_receiver_sm.sv
// IR packet receiver: frames start/select/bit bursts into a 4-bit
// drive command and drops the command to stop when the link goes quiet.
module ir_receiver_sm
    import ir_pkg::*;
#(
    parameter int ENV_TIMEOUT  = 4000,
    parameter int START_PULSES = IR_START_PULSES,
    parameter int SEL_PULSES   = IR_SEL_PULSES,
    parameter int ZERO_PULSES  = IR_ZERO_PULSES,
    parameter int ONE_PULSES   = IR_ONE_PULSES,
    parameter int TOL          = IR_TOL,
    parameter int MAX_GAP      = 200000,
    parameter int LINK_TIMEOUT = 25000000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IR_IN,
    output logic [CMD_BITS-1:0] COMMAND_OUT,
    output logic                CMD_VALID,
    output logic                PKT_ERROR,
    output logic                LINK_UP
);

    localparam int GW = $clog2(MAX_GAP + 1);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);

    logic                env;
    logic                burst_end;
    logic [PULSE_W-1:0]  pulse_count;
    burst_class_t        cls;
    logic                gap_expired;

    ir_state_t           state;
    logic [1:0]          bit_idx;
    logic [CMD_BITS-1:0] shift_q;
    logic [GW-1:0]       gap_cnt;
    logic [LW-1:0]       link_cnt;

    ir_envelope_detector #(
        .ENV_TIMEOUT (ENV_TIMEOUT)
    ) u_env (
        .CLK         (CLK),
        .RESET       (RESET),
        .IR_IN       (IR_IN),
        .ENV         (env),
        .BURST_END   (burst_end),
        .PULSE_COUNT (pulse_count)
    );

    // Classify the count of the burst that just ended
    always_comb begin
        cls          = '0;
        cls.is_start = count_match(pulse_count, START_PULSES, TOL);
        cls.is_sel   = count_match(pulse_count, SEL_PULSES, TOL);
        cls.is_zero  = count_match(pulse_count, ZERO_PULSES, TOL);
        cls.is_one   = count_match(pulse_count, ONE_PULSES, TOL);
    end

    // Envelope low for too long inside a packet
    assign gap_expired = !env && (gap_cnt == GW'(MAX_GAP - 1));

    // Packet framing, gap and link timers, registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            bit_idx     <= '0;
            shift_q     <= '0;
            gap_cnt     <= '0;
            link_cnt    <= '0;
            COMMAND_OUT <= '0;
            CMD_VALID   <= 1'b0;
            PKT_ERROR   <= 1'b0;
            LINK_UP     <= 1'b0;
        end else begin
            CMD_VALID <= 1'b0;
            PKT_ERROR <= 1'b0;

            if (link_cnt != '0) begin
                link_cnt <= link_cnt - 1'b1;
                if (link_cnt == LW'(1)) begin
                    COMMAND_OUT <= '0;
                    LINK_UP     <= 1'b0;
                end
            end

            if ((state == SEL || state == BITS) && !env) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            unique case (state)
                IDLE: begin
                    if (burst_end && cls.is_start) begin
                        state <= SEL;
                    end
                end
                SEL: begin
                    if (burst_end) begin
                        if (cls.is_sel) begin
                            state   <= BITS;
                            bit_idx <= '0;
                        end else begin
                            PKT_ERROR <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (gap_expired) begin
                        PKT_ERROR <= 1'b1;
                        state     <= IDLE;
                    end
                end
                BITS: begin
                    if (burst_end) begin
                        if (cls.is_zero || cls.is_one) begin
                            shift_q[bit_idx] <= cls.is_one;
                            bit_idx          <= bit_idx + 1'b1;
                            if (bit_idx == 2'd3) begin
                                state <= DONE;
                            end
                        end else begin
                            PKT_ERROR <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (gap_expired) begin
                        PKT_ERROR <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DONE: begin
                    // Placed last so a coincident expiry loses
                    COMMAND_OUT <= shift_q;
                    CMD_VALID   <= 1'b1;
                    LINK_UP     <= 1'b1;
                    link_cnt    <= LW'(LINK_TIMEOUT);
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_receiver_sm.sv
// Directed bench for ir_receiver_sm: packet table plus corner sequences
// (gap abort, noise, mid-packet reset, link expiry, output latency).
module tb_ir_receiver_sm;

    localparam int ENV_T  = 20;
    localparam int GAP_T  = 300;
    localparam int LINK_T = 12000;
    localparam int BGAP   = 40;

    logic       CLK;
    logic       RESET;
    logic       IR_IN;
    logic [3:0] COMMAND_OUT;
    logic       CMD_VALID;
    logic       PKT_ERROR;
    logic       LINK_UP;

    int cyc;
    int last_rise_cyc;
    int valid_cnt;
    int err_cnt;
    int valid_cyc;
    int err_cyc;
    int checks;
    int errors;

    typedef struct {
        string      name;
        int         s;
        int         l;
        int         b0;
        int         b1;
        int         b2;
        int         b3;
        logic       exp_v;
        logic       exp_e;
        logic [3:0] exp_cmd;
    } vec_t;

    vec_t vecs[13];

    ir_receiver_sm #(
        .ENV_TIMEOUT  (ENV_T),
        .MAX_GAP      (GAP_T),
        .LINK_TIMEOUT (LINK_T)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IR_IN       (IR_IN),
        .COMMAND_OUT (COMMAND_OUT),
        .CMD_VALID   (CMD_VALID),
        .PKT_ERROR   (PKT_ERROR),
        .LINK_UP     (LINK_UP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        valid_cnt = 0;
        err_cnt   = 0;
        valid_cyc = 0;
        err_cyc   = 0;
    end

    always @(negedge CLK) begin
        if (CMD_VALID) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (PKT_ERROR) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // n carrier periods of 8 cycles, then gap cycles of silence
    task automatic burst(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            IR_IN = 1'b1;
            last_rise_cyc = cyc;
            repeat (4) @(negedge CLK);
            IR_IN = 1'b0;
            repeat (3) @(negedge CLK);
        end
        repeat (gap) @(negedge CLK);
    endtask

    task automatic packet(input int s, input int l, input int b0,
                          input int b1, input int b2, input int b3);
        burst(s, BGAP);
        burst(l, BGAP);
        burst(b0, BGAP);
        burst(b1, BGAP);
        burst(b2, BGAP);
        burst(b3, BGAP);
        repeat (20) @(negedge CLK);
    endtask

    initial begin
        int v0;
        int e0;
        int r;
        int vt;
        int guard;

        checks = 0;
        errors = 0;
        last_rise_cyc = 0;
        RESET = 1'b1;
        IR_IN = 1'b0;

        vecs[0]  = '{"nom_0100",  88, 22, 20, 20, 47, 20, 1'b1, 1'b0, 4'b0100};
        vecs[1]  = '{"plus4",     92, 26, 24, 51, 24, 51, 1'b1, 1'b0, 4'b1010};
        vecs[2]  = '{"sel_p5",    88, 27, 20, 20, 20, 20, 1'b0, 1'b1, 4'b1010};
        vecs[3]  = '{"minus4",    84, 18, 43, 43, 16, 16, 1'b1, 1'b0, 4'b0011};
        vecs[4]  = '{"sel_m5",    88, 17, 47, 47, 47, 47, 1'b0, 1'b1, 4'b0011};
        vecs[5]  = '{"zero_p5",   88, 22, 25, 20, 47, 20, 1'b0, 1'b1, 4'b0011};
        vecs[6]  = '{"all_ones",  88, 22, 47, 47, 47, 47, 1'b1, 1'b0, 4'b1111};
        vecs[7]  = '{"one_m5",    88, 22, 47, 20, 42, 20, 1'b0, 1'b1, 4'b1111};
        vecs[8]  = '{"start_p5",  93, 22, 20, 20, 47, 20, 1'b0, 1'b0, 4'b1111};
        vecs[9]  = '{"right",     88, 22, 47, 20, 20, 20, 1'b1, 1'b0, 4'b0001};
        vecs[10] = '{"zero_m5",   88, 22, 15, 20, 20, 20, 1'b0, 1'b1, 4'b0001};
        vecs[11] = '{"start_m5",  83, 22, 20, 20, 47, 20, 1'b0, 1'b0, 4'b0001};
        vecs[12] = '{"one_p5",    88, 22, 52, 20, 20, 20, 1'b0, 1'b1, 4'b0001};

        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_cmd",   32'(COMMAND_OUT), 32'h0);
        check("rst_valid", 32'(CMD_VALID),   32'h0);
        check("rst_err",   32'(PKT_ERROR),   32'h0);
        check("rst_link",  32'(LINK_UP),     32'h0);
        repeat (10) @(negedge CLK);

        for (int i = 0; i < 13; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            packet(vecs[i].s, vecs[i].l, vecs[i].b0,
                   vecs[i].b1, vecs[i].b2, vecs[i].b3);
            check({vecs[i].name, "_valid"}, 32'(valid_cnt - v0),
                  32'(vecs[i].exp_v));
            check({vecs[i].name, "_err"}, 32'(err_cnt - e0),
                  32'(vecs[i].exp_e));
            check({vecs[i].name, "_cmd"}, 32'(COMMAND_OUT),
                  32'(vecs[i].exp_cmd));
            check({vecs[i].name, "_link"}, 32'(LINK_UP), 32'h1);
            if (i == 0) begin
                check("valid_latency", 32'(valid_cyc - last_rise_cyc),
                      32'(ENV_T + 5));
            end
        end

        // error latency on a bad select burst
        e0 = err_cnt;
        burst(88, BGAP);
        burst(30, 0);
        r = last_rise_cyc;
        repeat (BGAP) @(negedge CLK);
        check("selerr_count", 32'(err_cnt - e0), 32'h1);
        check("selerr_latency", 32'(err_cyc - r), 32'(ENV_T + 4));
        repeat (20) @(negedge CLK);

        // packet abandoned after two bits
        v0 = valid_cnt;
        e0 = err_cnt;
        burst(88, BGAP);
        burst(22, BGAP);
        burst(20, BGAP);
        burst(47, BGAP);
        repeat (GAP_T + 50) @(negedge CLK);
        check("gap_err", 32'(err_cnt - e0), 32'h1);
        check("gap_novalid", 32'(valid_cnt - v0), 32'h0);
        packet(88, 22, 20, 20, 47, 47);
        check("gap_recover_valid", 32'(valid_cnt - v0), 32'h1);
        check("gap_recover_cmd", 32'(COMMAND_OUT), 32'hc);
        check("gap_total_err", 32'(err_cnt - e0), 32'h1);

        // noise burst while idle
        v0 = valid_cnt;
        e0 = err_cnt;
        burst(30, BGAP);
        packet(88, 22, 47, 20, 47, 20);
        check("noise_err", 32'(err_cnt - e0), 32'h0);
        check("noise_valid", 32'(valid_cnt - v0), 32'h1);
        check("noise_cmd", 32'(COMMAND_OUT), 32'h5);

        // reset during the third bit
        burst(88, BGAP);
        burst(22, BGAP);
        burst(20, BGAP);
        burst(47, BGAP);
        burst(10, 0);
        v0 = valid_cnt;
        e0 = err_cnt;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mrst_cmd",   32'(COMMAND_OUT), 32'h0);
        check("mrst_link",  32'(LINK_UP),     32'h0);
        check("mrst_valid", 32'(CMD_VALID),   32'h0);
        check("mrst_err",   32'(PKT_ERROR),   32'h0);
        @(negedge CLK);
        check("mrst_valid2", 32'(CMD_VALID), 32'h0);
        check("mrst_err2",   32'(PKT_ERROR), 32'h0);
        burst(10, BGAP);
        packet(88, 22, 20, 47, 47, 20);
        check("mrst_next_valid", 32'(valid_cnt - v0), 32'h1);
        check("mrst_next_err",   32'(err_cnt - e0),   32'h0);
        check("mrst_next_cmd",   32'(COMMAND_OUT),    32'h6);
        check("mrst_next_link",  32'(LINK_UP),        32'h1);

        // link expiry after one packet
        packet(88, 22, 47, 20, 20, 47);
        check("exp_cmd_loaded", 32'(COMMAND_OUT), 32'h9);
        v0 = valid_cnt;
        vt = valid_cyc;
        guard = 0;
        while (cyc < vt + LINK_T - 1 && guard < LINK_T + 100) begin
            @(negedge CLK);
            guard = guard + 1;
        end
        check("exp_wait_bound", 32'(cyc), 32'(vt + LINK_T - 1));
        check("exp_link_before", 32'(LINK_UP), 32'h1);
        check("exp_cmd_before", 32'(COMMAND_OUT), 32'h9);
        @(negedge CLK);
        check("exp_link_after", 32'(LINK_UP), 32'h0);
        check("exp_cmd_after", 32'(COMMAND_OUT), 32'h0);
        repeat (10) @(negedge CLK);
        check("exp_no_valid", 32'(valid_cnt - v0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
